obstacle_field: RTL and testbench
=================================

# obstacle_field

Scene-generation stage that feeds the VGA colour mapper: for every pixel it produces the 4-bit palette index (`pix`) and `drawing` flag consumed by the bit-change/colour stage. It owns up to NSLOT scrolling obstacles. These spawn pseudo-randomly at the right screen edge, move left once per frame and retire at the left edge. The block also detects duck/obstacle collisions and sequences the game run/crash state.

## Interface
- NSLOT, 4, number of obstacle slots (1–8)
- CIDXW, 3, `pix` MSB index (`pix` is CIDXW+1 bits)
- SPEED, 2, pixels moved left per frame (1–8)
- MIN_GAP, 26, minimum frames between spawns (1–255)
- GROUND_Y, 400, vCount of the ground line (obstacles rest above it)
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse once per frame, during vertical blank
- run  in  1  game-active level from the control FSM
- hCount, vCount  in  10 each  current raster position
- bright  in  1  visible-area flag
- duck_drawing  in  1  duck sprite covers the current hCount/vCount
- pix  out  CIDXW+1  palette index, registered
- drawing  out  1  an obstacle covers the pixel, registered
- passed  out  1  one-cycle pulse when an obstacle retires (score increment)
- crashed  out  1  high while in CRASHED

## Operation
- **Reset values:** state IDLE; all slots free; `pix`=4'b0001; `drawing`=0; `passed`=0; `crashed`=0; LFSR=16'hACE1; gap_cnt=0.
- **Slot:** valid bit, type (2 b), xpos (10 b, hCount units).
- **Geometry:**
  - Type 1, low: 16×32, rows GROUND_Y-32..GROUND_Y-1, index 4'b0100.
  - Type 2, tall: 16×48, rows GROUND_Y-48..GROUND_Y-1, index 4'b0111.
  - Type 3, bird: 24×16, rows GROUND_Y-72..GROUND_Y-57, index 4'b0110.
  - Horizontal cover is `hCount` in [xpos, xpos+W).
- **Pixel:** lowest-index covering slot wins. If no slot covers, or `bright`=0: `pix`=4'b0001, `drawing`=0.
- **States:**
  - IDLE: `run`=1 → RUN. On entry to RUN, clear all slots and gap_cnt.
  - RUN: motion and spawning are active. A collision moves the block to CRASHED.
  - CRASHED: slots are frozen but still drawn. `run`=0 → IDLE.
  - In IDLE, slots hold and continue to be drawn.
- **Collision:** in RUN, `bright` && `duck_drawing` && any slot covers the current pixel (combinational cover, same cycle) → CRASHED on the next edge.
- **Frame update (RUN && frame_tick):**
  - Each valid slot with xpos < 144+SPEED is freed; `passed` pulses for one cycle.
  - Otherwise xpos ← xpos−SPEED.
  - The LFSR advances one step (x^16+x^14+x^13+x^11+1), only on these ticks.
  - gap_cnt increments, saturating at 255.
- **Spawn (same tick):** requires gap_cnt ≥ MIN_GAP, LFSR[1:0] ≠ 0 (using the pre-advance value) and at least one free slot.
  - The lowest free slot gets type=LFSR[1:0] and xpos=784; gap_cnt ← 0.
  - With no free slot, the spawn is skipped and gap_cnt keeps saturating.
  - A slot freed this tick is not reusable until the next tick.
- **Retirement spacing:** at most one slot retires per tick, guaranteed by MIN_GAP×SPEED ≥ 24.
- **Collision vs. frame_tick:** collision takes priority. Frozen positions are those after the tick update.
- **Reset mid-frame:** all state returns to the reset values immediately.

## Timing
- `pix`/`drawing`: 1-cycle latency from hCount/vCount.
- `passed`, slot updates: registered on the frame_tick edge, visible the next cycle.
- `crashed`: asserts 1 cycle after the colliding pixel.
- xpos arithmetic is 10-bit unsigned. The retire test precedes the subtraction, so xpos never underflows.

## Configuration
- `OBST_BIRD_EN` defined: type 3 (bird) spawns as specified.
- Not defined: LFSR[1:0]=3 maps to type 1. Bird geometry logic is compiled out.

## Structure
- Package `obst_pkg`:
  - type enum (NONE, LOW, TALL, BIRD)
  - width/height per type
  - palette indices 4'b0001/0100/0111/0110
  - screen bounds 144/784
  - FSM state enum
  - LFSR seed
- Sub-module `obst_lfsr`: 16-bit Galois LFSR with enable and seed parameter.

## Test plan
- **Reset/idle:** reset, then hold `run`=0 for 3 frames → `pix`=4'b0001, `drawing`=0, no slots valid.
- **Spawn:** `run`=1, with defaults and seed ACE1 → first spawn on tick 27 (if LFSR[1:0]≠0) at xpos 784. On the next tick xpos=782, and the pixel at (782, GROUND_Y-1) yields that type's index after 1 cycle.
- **Retire:** force a slot to xpos 145 → on the next tick the slot is freed and `passed` is high for exactly 1 cycle.
- **Collision:** `duck_drawing`=1 at a covered visible pixel → `crashed`=1 next cycle, and xpos unchanged over 5 ticks. Drop `run` → IDLE; raise `run` → slots cleared.
- **Full slots:** MIN_GAP=1, SPEED=1 → no more than NSLOT valid slots, gap_cnt saturates at 255 without wrapping.
- **Macro:** without `OBST_BIRD_EN`, run 2000 ticks → no pixel ever returns 4'b0110.

Source files
------------

// File: rtl/obst_pkg.sv
// obst_pkg: obstacle types, geometry, palette, screen bounds, FSM states and LFSR seed.
// Bird geometry is only compiled in when OBST_BIRD_EN is defined.
package obst_pkg;
  typedef enum logic [1:0] {NONE, LOW, TALL, BIRD} obst_t;
  typedef enum logic [1:0] {IDLE, RUN, CRASHED} state_t;
  localparam logic [9:0] X_MIN = 10'd144;
  localparam logic [9:0] X_MAX = 10'd784;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [3:0] PIX_BG = 4'b0001;
  localparam logic [3:0] PIX_LOW = 4'b0100;
  localparam logic [3:0] PIX_TALL = 4'b0111;
  localparam logic [3:0] PIX_BIRD = 4'b0110;
  localparam int LOW_W = 16;
  localparam int LOW_H = 32;
  localparam int TALL_H = 48;
  localparam int BIRD_W = 24;
  localparam int BIRD_H = 16;
  localparam int BIRD_TOP = 72;
  function automatic logic [3:0] obst_pix(input obst_t t);
    return t == LOW ? PIX_LOW : t == TALL ? PIX_TALL : t == BIRD ? PIX_BIRD : PIX_BG;
  endfunction
  function automatic logic obst_cover(input obst_t t, input logic [9:0] x, input logic [9:0] h,
                                      input logic [9:0] v, input int gy);
    int w, y0, y1;
    logic ok;
`ifdef OBST_BIRD_EN
    ok = t != NONE;
`else
    ok = t == LOW || t == TALL;
`endif
    w = t == BIRD ? BIRD_W : LOW_W;
    y0 = t == LOW ? gy - LOW_H : t == TALL ? gy - TALL_H : gy - BIRD_TOP;
    y1 = t == BIRD ? y0 + BIRD_H : gy;
    return ok && int'(h) >= int'(x) && int'(h) < int'(x) + w && int'(v) >= y0 && int'(v) < y1;
  endfunction
endpackage

// File: rtl/obst_lfsr.sv
// obst_lfsr: 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) with enable; exposes the low two bits.
module obst_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [1:0] low
);
  logic [15:0] st;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= SEED;
    else if (en) st <= {1'b0, st[15:1]} ^ (st[0] ? 16'hB400 : 16'h0000);
  assign low = st[1:0];
endmodule

// File: rtl/obstacle_field.sv
// obstacle_field: scrolling obstacle slots, pixel index generation, collision and run/crash sequencing.
// Define OBST_BIRD_EN to let LFSR value 3 spawn birds; otherwise it spawns a low obstacle.
module obstacle_field
  import obst_pkg::*;
#(
  parameter int NSLOT = 4,
  parameter int CIDXW = 3,
  parameter int SPEED = 2,
  parameter int MIN_GAP = 26,
  parameter int GROUND_Y = 400
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           frame_tick,
  input  logic           run,
  input  logic [9:0]     hCount,
  input  logic [9:0]     vCount,
  input  logic           bright,
  input  logic           duck_drawing,
  output logic [CIDXW:0] pix,
  output logic           drawing,
  output logic           passed,
  output logic           crashed
);
  state_t state;
  logic [NSLOT-1:0] valid, hit, retire, free_oh;
  obst_t typ [NSLOT];
  logic [9:0] xpos [NSLOT];
  logic [7:0] gap_cnt;
  logic [1:0] rnd;
  logic [3:0] sel;
  obst_t new_t;
  logic tick, spawn, collide;
  assign tick = state == RUN && frame_tick;
  obst_lfsr #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst_n(rst_n), .en(tick), .low(rnd));
`ifdef OBST_BIRD_EN
  assign new_t = obst_t'(rnd);
`else
  assign new_t = rnd == 2'd3 ? LOW : obst_t'(rnd);
`endif
  // Loop runs high to low so the lowest covering slot ends up selected.
  always_comb begin
    hit = '0;
    retire = '0;
    sel = PIX_BG;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      hit[i] = valid[i] && obst_cover(typ[i], xpos[i], hCount, vCount, GROUND_Y);
      retire[i] = valid[i] && xpos[i] < X_MIN + 10'(SPEED);
      sel = hit[i] ? obst_pix(typ[i]) : sel;
    end
  end
  assign free_oh = ~valid & (valid + 1'b1);
  assign spawn = int'(gap_cnt) >= MIN_GAP && rnd != 2'd0 && |free_oh;
  assign collide = state == RUN && bright && duck_drawing && |hit;
  assign crashed = state == CRASHED;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      valid <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        typ[i] <= NONE;
        xpos[i] <= '0;
      end
      gap_cnt <= '0;
      passed <= 1'b0;
      pix <= (CIDXW+1)'(PIX_BG);
      drawing <= 1'b0;
    end else begin
      pix <= bright && |hit ? (CIDXW+1)'(sel) : (CIDXW+1)'(PIX_BG);
      drawing <= bright && |hit;
      passed <= tick && |retire;
      if (state == IDLE && run) begin
        state <= RUN;
        valid <= '0;
        gap_cnt <= '0;
      end else if (state == CRASHED && !run) state <= IDLE;
      if (collide) state <= CRASHED;
      if (tick) begin
        for (int i = 0; i < NSLOT; i++)
          if (spawn && free_oh[i]) begin
            valid[i] <= 1'b1;
            typ[i] <= new_t;
            xpos[i] <= X_MAX;
          end else if (retire[i]) valid[i] <= 1'b0;
          else if (valid[i]) xpos[i] <= xpos[i] - 10'(SPEED);
        gap_cnt <= spawn ? 8'd0 : gap_cnt == 8'hFF ? gap_cnt : gap_cnt + 8'd1;
      end
    end
endmodule

// File: tb/tb_obstacle_field.sv
// tb_obstacle_field: randomized raster/tick stimulus against a behavioural scene model.
module tb_obstacle_field;
  localparam int GY = 400;
  logic clk = 0, rst_n = 0, frame_tick = 0, run = 0, bright = 0, duck_drawing = 0;
  logic [9:0] hCount = 0, vCount = 0;
  logic [3:0] pix;
  logic drawing, passed, crashed;
  int n_chk = 0, n_err = 0, bird_seen = 0;
  int m_state, lfsr, gap;
  bit mv [4];
  int mt [4], mx [4];
  bit m_pass;
  obstacle_field dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .run(run), .hCount(hCount),
    .vCount(vCount), .bright(bright), .duck_drawing(duck_drawing), .pix(pix),
    .drawing(drawing), .passed(passed), .crashed(crashed)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic void m_reset();
    m_state = 0;
    lfsr = 'hACE1;
    gap = 0;
    m_pass = 0;
    foreach (mv[i]) begin mv[i] = 0; mt[i] = 0; mx[i] = 0; end
  endfunction
  // Palette index of the scene at (h,v), or -1 where no obstacle is present.
  function automatic int scene(int h, int v);
    for (int i = 0; i < 4; i++) begin
      int w, top, bot;
      if (!mv[i]) continue;
      w = mt[i] == 3 ? 24 : 16;
      top = mt[i] == 1 ? GY - 32 : mt[i] == 2 ? GY - 48 : GY - 72;
      bot = mt[i] == 3 ? GY - 56 : GY;
      if (h >= mx[i] && h < mx[i] + w && v >= top && v < bot)
        return mt[i] == 1 ? 4 : mt[i] == 2 ? 7 : 6;
    end
    return -1;
  endfunction
  function automatic void frame_update();
    int fs = -1, r = lfsr & 3;
    bit sp;
    for (int i = 3; i >= 0; i--) if (!mv[i]) fs = i;
    sp = gap >= 26 && r != 0 && fs >= 0;
    for (int i = 0; i < 4; i++)
      if (mv[i]) begin
        if (mx[i] < 146) begin mv[i] = 0; m_pass = 1; end
        else mx[i] -= 2;
      end
    if (sp) begin
      mv[fs] = 1;
`ifdef OBST_BIRD_EN
      mt[fs] = r;
`else
      mt[fs] = r == 3 ? 1 : r;
`endif
      mx[fs] = 784;
      gap = 0;
    end else if (gap < 255) gap++;
    lfsr = (lfsr >> 1) ^ ((lfsr & 1) != 0 ? 'hB400 : 0);
  endfunction
  task automatic step(input bit tk, input bit r, input int h, input int v, input bit b, input bit d);
    int cp;
    bit coll, e_draw;
    frame_tick = tk; run = r; hCount = 10'(h); vCount = 10'(v); bright = b; duck_drawing = d;
    cp = scene(h, v);
    e_draw = b && cp >= 0;
    coll = m_state == 1 && b && d && cp >= 0;
    m_pass = 0;
    if (m_state == 0 && r) begin
      m_state = 1;
      foreach (mv[i]) mv[i] = 0;
      gap = 0;
    end else if (m_state == 1) begin
      if (tk) frame_update();
      if (coll) m_state = 2;
    end else if (m_state == 2 && !r) m_state = 0;
    @(posedge clk);
    #1;
    chk("pix", pix, e_draw ? cp : 1);
    chk("drawing", drawing, e_draw);
    chk("passed", passed, m_pass);
    chk("crashed", crashed, m_state == 2);
    if (pix == 4'b0110) bird_seen++;
    frame_tick = 0;
  endtask
  task automatic rnd_step(input bit r, input bit duck_en);
    int k = $urandom_range(0, 3), h, v;
    if ($urandom_range(0, 1) == 1 && mv[k]) begin
      h = mx[k] + $urandom_range(0, 30) - 3;
      v = $urandom_range(GY - 80, GY + 2);
    end else begin
      h = $urandom_range(0, 799);
      v = $urandom_range(0, 524);
    end
    step($urandom_range(0, 3) == 0, r, h, v, $urandom_range(0, 7) != 0,
         duck_en && $urandom_range(0, 3) == 0);
  endtask
  task automatic probe_slots(input bit r);
    for (int i = 0; i < 4; i++)
      if (mv[i]) step(0, r, mx[i] + 1, mt[i] == 3 ? GY - 60 : GY - 1, 1, 0);
  endtask
  initial begin
    m_reset();
    repeat (3) @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk);
    #1;
    chk("reset_pix", pix, 1);
    chk("reset_crashed", crashed, 0);
    for (int f = 0; f < 3; f++) begin
      repeat (6) rnd_step(0, 0);
      step(1, 0, 300, GY - 1, 1, 0);
    end
    step(0, 1, 0, 0, 0, 0);
    repeat (28) step(1, 1, 0, 0, 0, 0);
    step(0, 1, 782, GY - 1, 1, 0);
    step(0, 1, 790, GY - 1, 1, 0);
    repeat (6000) rnd_step(1, 0);
    for (int n = 0; n < 4000 && m_state != 2; n++) rnd_step(1, 1);
    chk("crash_reached", crashed, 1);
    repeat (5) step(1, 1, 0, 0, 0, 0);
    probe_slots(1);
    step(0, 0, 0, 0, 0, 0);
    probe_slots(0);
    repeat (4) rnd_step(0, 0);
    for (int i = 0; i < 4; i++) begin
      int ox = mx[i], ot = mt[i];
      bit ov = mv[i];
      step(0, 1, 0, 0, 0, 0);
      if (ov) step(0, 1, ox + 1, ot == 3 ? GY - 60 : GY - 1, 1, 0);
    end
    repeat (2400) rnd_step(1, 0);
    #1 rst_n = 0;
    #2;
    m_reset();
    chk("async_rst_pix", pix, 1);
    chk("async_rst_draw", drawing, 0);
    chk("async_rst_passed", passed, 0);
    chk("async_rst_crashed", crashed, 0);
    #1 rst_n = 1;
    repeat (20) rnd_step(0, 0);
`ifndef OBST_BIRD_EN
    chk("no_bird_pix", bird_seen, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
